// File: rtl/gpio_input_conditioner.sv
// Purpose: per-pin synchroniser and debouncer. Outputs a clean level and one-cycle rise/fall pulses.
// Latency: SYNC_STAGES cycles, then the wait to the DB_COUNT-th sample tick, then 1 register cycle.
// Backpressure: none. Outputs are free-running. Optional GPIO_EVENT_LATCH_EN adds sticky event flags.
module gpio_input_conditioner #(
    parameter int WIDTH       = 34,
    parameter int SYNC_STAGES = 2,
    parameter int PRESCALE    = 1000,
    parameter int DB_COUNT    = 4
) (
    input  logic             clk,
    input  logic             gated_reset,
    input  logic [WIDTH-1:0] gpio_in,
    input  logic             sample_en,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
`ifdef GPIO_EVENT_LATCH_EN
    input  logic [WIDTH-1:0] evt_clear,
    output logic [WIDTH-1:0] evt_flags,
`endif
    output logic             tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CW = $clog2(DB_COUNT + 1);
    localparam logic [PW-1:0] PS_MAX  = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_COUNT - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync;
    logic [PW-1:0]                     ps_cnt;
    logic [WIDTH-1:0][CW-1:0]          cnt_q;
    logic [WIDTH-1:0][CW-1:0]          cnt_nxt;
    logic [WIDTH-1:0]                  level_nxt;
    logic [WIDTH-1:0]                  rise_nxt;
    logic [WIDTH-1:0]                  fall_nxt;

    assign sync = sync_q[SYNC_STAGES-1];

    // Bring the raw pins into the clk domain through a multi-flop chain.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Shared prescaler. It produces a registered one-cycle tick every PRESCALE enabled cycles.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (sample_en) begin
            if (ps_cnt == PS_MAX) begin
                ps_cnt <= '0;
                tick   <= 1'b1;
            end else begin
                ps_cnt <= ps_cnt + PW'(1);
                tick   <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Per-channel debounce decision. The registered tick qualifies every update.
    always_comb begin
        cnt_nxt   = cnt_q;
        level_nxt = level_out;
        rise_nxt  = '0;
        fall_nxt  = '0;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] == level_out[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    cnt_nxt[i]   = '0;
                    level_nxt[i] = sync[i];
                    rise_nxt[i]  = sync[i];
                    fall_nxt[i]  = ~sync[i];
                end else begin
                    cnt_nxt[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state and outputs. Each pulse appears in the first cycle of the new level.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            cnt_q      <= '0;
            level_out  <= '0;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            cnt_q      <= cnt_nxt;
            level_out  <= level_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

`ifdef GPIO_EVENT_LATCH_EN
    // Sticky per-channel event flags. A new edge beats a clear in the same cycle.
    always_ff @(posedge clk or negedge gated_reset) begin
        if (!gated_reset) begin
            evt_flags <= '0;
        end else begin
            evt_flags <= (evt_flags & ~evt_clear) | rise_pulse | fall_pulse;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
`timescale 1ns/1ps
// Bench for gpio_input_conditioner with WIDTH=4, SYNC_STAGES=2, PRESCALE=4, DB_COUNT=3.
// Stimulus queues the expected pulse events. A monitor pops one event per pulse cycle and compares it.
// Event timing is given as the index of the sample tick that should produce the pulse.
module tb_gpio_input_conditioner;

    logic       clk = 1'b0;
    logic       gated_reset = 1'b0;
    logic [3:0] gpio_in = 4'h0;
    logic       sample_en = 1'b0;
    logic [3:0] level_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       tick;
`ifdef GPIO_EVENT_LATCH_EN
    logic [3:0] evt_clear = 4'h0;
    logic [3:0] evt_flags;
`endif

    gpio_input_conditioner #(
        .WIDTH(4), .SYNC_STAGES(2), .PRESCALE(4), .DB_COUNT(3)
    ) dut (
        .clk        (clk),
        .gated_reset(gated_reset),
        .gpio_in    (gpio_in),
        .sample_en  (sample_en),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
`ifdef GPIO_EVENT_LATCH_EN
        .evt_clear  (evt_clear),
        .evt_flags  (evt_flags),
`endif
        .tick       (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] level;
        int         tk;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   tick_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue one pulse event, expected a given number of ticks after the current one.
    task automatic expect_ev(input logic [3:0] r, input logic [3:0] f, input logic [3:0] l, input int ahead);
        exp_t e;
        e.rise  = r;
        e.fall  = f;
        e.level = l;
        e.tk    = tick_cnt + ahead;
        exp_q.push_back(e);
    endtask

    // Return just after the negedge of the next tick cycle. The monitor has already counted that tick.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
        if (!tick) chk("tick_timeout", {31'b0, tick}, 32'd1);
        #1;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor. Every cycle that shows a pulse consumes one queued event.
    always @(negedge clk) begin
        if (gated_reset && ((rise_pulse | fall_pulse) != 4'h0)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {24'b0, rise_pulse, fall_pulse}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_rise",  {28'b0, rise_pulse}, {28'b0, mon_e.rise});
                chk("ev_fall",  {28'b0, fall_pulse}, {28'b0, mon_e.fall});
                chk("ev_level", {28'b0, level_out},  {28'b0, mon_e.level});
                chk("ev_tick_index", tick_cnt, mon_e.tk);
            end
        end
        if (tick) tick_cnt++;
    end

    initial begin
        // 1. Reset with all pins high. Nothing may leak through.
        gated_reset = 1'b0;
        gpio_in     = 4'hF;
        sample_en   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_level", {28'b0, level_out}, 32'h0);
        chk("rst_rise",  {28'b0, rise_pulse}, 32'h0);
        chk("rst_fall",  {28'b0, fall_pulse}, 32'h0);
        chk("rst_tick",  {31'b0, tick}, 32'h0);
`ifdef GPIO_EVENT_LATCH_EN
        chk("rst_flags", {28'b0, evt_flags}, 32'h0);
`endif
        gpio_in     = 4'h0;
        sample_en   = 1'b1;
        #1 gated_reset = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk("rel_tick",  {31'b0, tick}, {31'b0, ((k % 4) == 0)});
            chk("rel_level", {28'b0, level_out}, 32'h0);
            chk("rel_pulse", {24'b0, rise_pulse, fall_pulse}, 32'h0);
        end

        // 2. Clean rise on channel 0. It is accepted on the 3rd tick.
        wait_tick();
        gpio_in = 4'h1;
        expect_ev(4'h1, 4'h0, 4'h1, 3);
        repeat (3) wait_tick();
        settle();
        chk("rise0_level", {28'b0, level_out}, 32'h1);

        // 3. Bounce on channel 1. The run of two, the gap of one and the run of two are rejected.
        wait_tick();
        gpio_in[1] = 1'b1;
        expect_ev(4'h2, 4'h0, 4'h3, 6);
        repeat (2) wait_tick();
        gpio_in[1] = 1'b0;
        wait_tick();
        gpio_in[1] = 1'b1;
        repeat (2) wait_tick();
        chk("bounce_hold", {28'b0, level_out}, 32'h1);
        wait_tick();
        settle();
        chk("bounce_accept", {28'b0, level_out}, 32'h3);

        // 4. Raise channel 2, then freeze the prescaler mid-way through its fall.
        wait_tick();
        gpio_in[2] = 1'b1;
        expect_ev(4'h4, 4'h0, 4'h7, 3);
        repeat (3) wait_tick();
        settle();
        wait_tick();
        gpio_in[2] = 1'b0;
        expect_ev(4'h0, 4'h4, 4'h3, 3);
        repeat (2) wait_tick();
        sample_en = 1'b0;
        repeat (50) begin
            @(negedge clk);
            chk("freeze_tick",  {31'b0, tick}, 32'h0);
            chk("freeze_level", {28'b0, level_out}, 32'h7);
        end
        #1 sample_en = 1'b1;
        wait_tick();
        settle();
        chk("thaw_level", {28'b0, level_out}, 32'h3);

        // 5. Move to 5, then swap every channel in one cycle.
        wait_tick();
        gpio_in = 4'h5;
        expect_ev(4'h4, 4'h2, 4'h5, 3);
        repeat (3) wait_tick();
        settle();
        wait_tick();
        gpio_in = 4'hA;
        expect_ev(4'hA, 4'h5, 4'hA, 3);
        repeat (3) wait_tick();
        settle();
        chk("swap_level", {28'b0, level_out}, 32'hA);

`ifdef GPIO_EVENT_LATCH_EN
        // 6a. Every channel has seen an edge. Clear the two low flags.
        chk("flags_all", {28'b0, evt_flags}, 32'hF);
        evt_clear = 4'h3;
        @(negedge clk);
        #1 evt_clear = 4'h0;
        chk("flags_clr", {28'b0, evt_flags}, 32'hC);
`endif

        // 6. Reset mid-operation. It clears at once and produces no fall pulses.
        gated_reset = 1'b0;
        #1;
        chk("mid_rst_level", {28'b0, level_out}, 32'h0);
        chk("mid_rst_rise",  {28'b0, rise_pulse}, 32'h0);
        chk("mid_rst_fall",  {28'b0, fall_pulse}, 32'h0);
        chk("mid_rst_tick",  {31'b0, tick}, 32'h0);
`ifdef GPIO_EVENT_LATCH_EN
        chk("mid_rst_flags", {28'b0, evt_flags}, 32'h0);
`endif
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_hold_fall",  {28'b0, fall_pulse}, 32'h0);
            chk("mid_rst_hold_level", {28'b0, level_out}, 32'h0);
        end
        chk("events_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_input_conditioner.md
Name: gpio_input_conditioner

Overview:
- Front-end stage between the breakout-board input pins (gpio_in) and the user design module inside the top-level wrapper.
- Per bit, it synchronises the raw pin into the clk domain and debounces it on a shared prescaled sample tick.
- Outputs a clean level plus single-cycle rising/falling edge pulses for the design to consume.

Parameters:
- WIDTH, 34, number of GPIO input channels.
- SYNC_STAGES, 2, synchroniser flops per channel (legal values >= 2).
- PRESCALE, 1000, clk cycles per sample tick (legal values >= 1).
- DB_COUNT, 4, consecutive differing ticks required to accept a new level (legal values >= 1).

Ports:
- clk  input  1  system clock.
- gated_reset  input  1  asynchronous, active-low reset.
- gpio_in  input  WIDTH  raw asynchronous pin levels.
- sample_en  input  1  prescaler/debounce enable.
- level_out  output  WIDTH  debounced level.
- rise_pulse  output  WIDTH  one-cycle pulse on accepted 0->1.
- fall_pulse  output  WIDTH  one-cycle pulse on accepted 1->0.
- tick  output  1  one-cycle sample strobe (for debug/bench).

Behaviour:
- Clock and reset: clk clocks every flop. gated_reset is asynchronous, active-low.
- Reset values: every flop clears to 0, so level_out=0, rise_pulse=0, fall_pulse=0, tick=0. The prescaler, stable counters and sync chains also clear to 0.
- Reset mid-operation: outputs clear immediately. No fall pulses are generated by reset.
- Synchroniser: SYNC_STAGES-deep flop chain per bit. sync[i] is the last stage.
- Prescaler:
  - Counter width $clog2(PRESCALE), minimum 1 bit.
  - When sample_en=1, it increments each cycle. At PRESCALE-1 it wraps to 0 and tick is registered high for exactly one cycle.
  - When sample_en=0, counter holds and tick=0.
  - PRESCALE=1 means tick is high every enabled cycle.
- Debounce, per channel, counter cnt[i] of width $clog2(DB_COUNT+1). On each tick:
  - If sync[i]==level_out[i]: cnt[i]<=0.
  - Else if cnt[i]==DB_COUNT-1: level_out[i]<=sync[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
  - Cycles without tick leave cnt[i] and level_out[i] unchanged.
- Bounce: any tick where the input equals the current level resets the count. A change is accepted only after DB_COUNT consecutive differing ticks.
- Edge pulses:
  - rise_pulse[i] and fall_pulse[i] are registered on the same edge that updates level_out[i]. The pulse is high during the first cycle of the new level and low the next cycle.
  - rise_pulse[i] and fall_pulse[i] are never high together.
  - Multiple channels may pulse in the same cycle.
- Latency: pin change to level_out is SYNC_STAGES cycles plus the wait to the DB_COUNT-th subsequent tick, plus 1 register cycle.
- Channels are fully independent; only the prescaler is shared.

Optional Feature:
- Macro: GPIO_EVENT_LATCH_EN.
- Defined: adds input evt_clear [WIDTH] and output evt_flags [WIDTH], reset 0.
  - evt_flags[i] sets on rise_pulse[i] or fall_pulse[i].
  - evt_flags[i] clears when evt_clear[i]=1.
  - Set wins on a same-cycle set and clear.
- Not defined: these ports and flops do not exist; all other behaviour is identical.

Test Plan (all scenarios use WIDTH=4, SYNC_STAGES=2, PRESCALE=4, DB_COUNT=3):
1. Reset: hold gated_reset=0 with gpio_in=4'hF -> level_out=4'h0, rise_pulse=0, fall_pulse=0, tick=0. Release with gpio_in=0, sample_en=1 -> tick high on cycles 4, 8, 12 after release, nothing else toggles.
2. Clean rise: from reset, gpio_in[0]=1 held, sample_en=1 -> level_out[0] goes 1 on the 3rd tick after sync[0]=1. rise_pulse=4'h1 for exactly that one cycle. fall_pulse stays 0.
3. Bounce rejected: with level_out[1]=0, drive gpio_in[1]=1 for 2 ticks, then 0 for 1 tick, then 1 for 2 ticks -> level_out[1] stays 0, no pulses. Holding 1 for a 3rd tick -> rise_pulse=4'h2.
4. Enable freeze: with cnt[2]=2 pending a 1->0 change, set sample_en=0 for 50 cycles -> tick=0 and level_out[2] unchanged. Re-enable -> fall_pulse=4'h4 on the next tick.
5. Simultaneous channels: level_out=4'h5, gpio_in changed to 4'hA in one cycle -> after 3 ticks level_out=4'hA, rise_pulse=4'hA and fall_pulse=4'h5 in the same single cycle.
6. Reset mid-op plus latch (GPIO_EVENT_LATCH_EN): after case 5, evt_flags=4'hF. Assert evt_clear=4'h3 -> evt_flags=4'hC. Assert gated_reset low -> all outputs 0 immediately, no fall pulses.
